// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared constants and types for the SC1602 frame scheduler:
//   FILL_CHAR  - code used to blank the frame buffer (ASCII space)
//   NCHAR      - frame buffer depth (2 rows x 16 columns)
//   ROW_LEN    - characters per panel row
//   ADDR_W     - width of buffer addresses / character index
//   CMD_*      - encodings presented on the driver's command_in
//   frame_state_t - frame FSM states
//   grant_t    - last-granted requester for the write arbiter
// -----------------------------------------------------------------------------
package lcd_pkg;

   localparam logic [7:0] FILL_CHAR = 8'h20;
   localparam int         NCHAR     = 32;
   localparam int         ROW_LEN   = 16;
   localparam int         ADDR_W    = 5;

   localparam logic [2:0] CMD_NOP     = 3'b000;
   localparam logic [2:0] CMD_SHIFT_L = 3'b010;
   localparam logic [2:0] CMD_SHIFT_R = 3'b011;

   typedef enum logic [1:0] {
      ST_CLEAR       = 2'd0,
      ST_IDLE        = 2'd1,
      ST_SHIFT_ISSUE = 2'd2,
      ST_SHIFT_WAIT  = 2'd3
   } frame_state_t;

   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_B = 1'b1
   } grant_t;

   // Shift command for a given direction (0 = left, 1 = right).
   function automatic logic [2:0] shift_cmd(input logic dir);
      return dir ? CMD_SHIFT_R : CMD_SHIFT_L;
   endfunction

endpackage

// File: rtl/lcd_wr_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_wr_arbiter
// Two-requester round-robin write arbiter for the frame buffer.
// Ports:
//   i_clk, i_reset          - clock, synchronous active-high reset
//   i_enable                - writes allowed this cycle
//   i_a_valid/addr/data     - requester A
//   i_b_valid/addr/data     - requester B
//   o_a_ready, o_b_ready    - combinational grants (write lands this edge)
//   o_we, o_addr, o_data    - single merged write port toward the buffer
// -----------------------------------------------------------------------------
module lcd_wr_arbiter
   import lcd_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic              i_a_valid,
   input  logic [ADDR_W-1:0] i_a_addr,
   input  logic [7:0]        i_a_data,
   input  logic              i_b_valid,
   input  logic [ADDR_W-1:0] i_b_addr,
   input  logic [7:0]        i_b_data,
   output logic              o_a_ready,
   output logic              o_b_ready,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_addr,
   output logic [7:0]        o_data
);

   grant_t r_last_grant;
   logic   w_grant_a;
   logic   w_grant_b;

   // A wins when alone or when B was served last; B takes whatever A does not.
   always_comb begin
      w_grant_a = i_enable & i_a_valid & (~i_b_valid | (r_last_grant == GRANT_B));
      w_grant_b = i_enable & i_b_valid & ~w_grant_a;
   end

   assign o_a_ready = w_grant_a;
   assign o_b_ready = w_grant_b;
   assign o_we      = w_grant_a | w_grant_b;
   assign o_addr    = w_grant_b ? i_b_addr : i_a_addr;
   assign o_data    = w_grant_b ? i_b_data : i_a_data;

   // Starts as "B served last" so A is preferred on the first contention.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_last_grant <= GRANT_B;
      end else if (w_grant_a) begin
         r_last_grant <= GRANT_A;
      end else if (w_grant_b) begin
         r_last_grant <= GRANT_B;
      end
   end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// -----------------------------------------------------------------------------
// lcd_frame_scheduler
// Owns the 32-entry character frame buffer for a 16x2 SC1602 panel, feeds the
// driver's character input in step with its refresh, arbitrates writes from
// two requesters and sequences display-shift commands.
// Ports:
//   i_clk, i_reset                 - clock, synchronous active-high reset
//   i_wr_a_valid/addr/data         - requester A write (addr 0-15 row 0, 16-31 row 1)
//   o_wr_a_ready                   - A write accepted this cycle
//   i_wr_b_valid/addr/data         - requester B write
//   o_wr_b_ready                   - B write accepted this cycle
//   i_clr_req                      - pulse: refill buffer with FILL_CHAR
//   i_shift_req, i_shift_dir       - pulse: one display shift (0 left, 1 right)
//   o_busy                         - clear or shift in progress
//   i_drv_drawing, i_drv_ready     - driver `drawing` and `ready_o`
//   o_character                    - to driver `character`
//   o_command_out                  - to driver `command_in`
// -----------------------------------------------------------------------------
module lcd_frame_scheduler
   import lcd_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_wr_a_valid,
   input  logic [ADDR_W-1:0] i_wr_a_addr,
   input  logic [7:0]        i_wr_a_data,
   output logic              o_wr_a_ready,
   input  logic              i_wr_b_valid,
   input  logic [ADDR_W-1:0] i_wr_b_addr,
   input  logic [7:0]        i_wr_b_data,
   output logic              o_wr_b_ready,
   input  logic              i_clr_req,
   input  logic              i_shift_req,
   input  logic              i_shift_dir,
   output logic              o_busy,
   input  logic              i_drv_drawing,
   input  logic              i_drv_ready,
   output logic [7:0]        o_character,
   output logic [2:0]        o_command_out
);

   frame_state_t      r_state;
   frame_state_t      w_state_next;
   logic [ADDR_W-1:0] r_clr_ptr;
   logic [ADDR_W-1:0] r_idx;
   logic              r_dir;
   logic              r_drawing_q;
   logic              r_drv_ready_q;
   logic [7:0]        r_character;
   logic [7:0]        r_buf [NCHAR];

   logic              w_arb_enable;
   logic              w_latch_dir;
   logic              w_arb_we;
   logic [ADDR_W-1:0] w_arb_addr;
   logic [7:0]        w_arb_data;
   logic              w_draw_fall;
   logic              w_ready_rise;
   logic              w_load;
   logic [ADDR_W-1:0] w_read_addr;
   logic              w_buf_we;
   logic [ADDR_W-1:0] w_buf_waddr;
   logic [7:0]        w_buf_wdata;

   // Edge detectors against the previous-cycle samples of the driver status.
   assign w_draw_fall  = r_drawing_q & ~i_drv_drawing;
   assign w_ready_rise = i_drv_ready & ~r_drv_ready_q;

   // Frame resync outranks the per-character advance.
   assign w_load      = w_ready_rise | w_draw_fall;
   assign w_read_addr = w_ready_rise ? '0 : r_idx + 1'b1;

   // ---------------------------------------------------------------- frame FSM
   always_comb begin
      w_state_next  = r_state;
      o_busy        = 1'b1;
      o_command_out = CMD_NOP;
      w_arb_enable  = 1'b0;
      w_latch_dir   = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            if (r_clr_ptr == ADDR_W'(NCHAR - 1)) begin
               w_state_next = ST_IDLE;
            end
         end
         ST_IDLE: begin
            o_busy       = 1'b0;
            w_arb_enable = 1'b1;
            // A clear request in the same cycle swallows the shift.
            if (i_clr_req) begin
               w_state_next = ST_CLEAR;
            end else if (i_shift_req) begin
               w_state_next = ST_SHIFT_ISSUE;
               w_latch_dir  = 1'b1;
            end
         end
         ST_SHIFT_ISSUE: begin
            o_command_out = shift_cmd(r_dir);
            w_arb_enable  = 1'b1;
            // Driver leaving HOME (ready low) means the command was taken.
            if (!i_drv_ready) begin
               w_state_next = ST_SHIFT_WAIT;
            end
         end
         ST_SHIFT_WAIT: begin
            w_arb_enable = 1'b1;
            if (w_ready_rise) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_CLEAR;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= ST_CLEAR;
         r_clr_ptr     <= '0;
         r_dir         <= 1'b0;
         r_drawing_q   <= 1'b0;
         r_drv_ready_q <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_drawing_q   <= i_drv_drawing;
         r_drv_ready_q <= i_drv_ready;
         // Pointer parks at 0 outside CLEAR so every clear sweeps 0..31.
         r_clr_ptr     <= (r_state == ST_CLEAR) ? r_clr_ptr + 1'b1 : '0;
         if (w_latch_dir) begin
            r_dir <= i_shift_dir;
         end
      end
   end

   // ---------------------------------------------------------------- arbiter
   lcd_wr_arbiter u_arbiter (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_enable  (w_arb_enable & ~i_reset),
      .i_a_valid (i_wr_a_valid),
      .i_a_addr  (i_wr_a_addr),
      .i_a_data  (i_wr_a_data),
      .i_b_valid (i_wr_b_valid),
      .i_b_addr  (i_wr_b_addr),
      .i_b_data  (i_wr_b_data),
      .o_a_ready (o_wr_a_ready),
      .o_b_ready (o_wr_b_ready),
      .o_we      (w_arb_we),
      .o_addr    (w_arb_addr),
      .o_data    (w_arb_data)
   );

   // ---------------------------------------------------------------- buffer
   // One write port shared between the clear sweep and the arbiter.
   always_comb begin
      w_buf_we    = w_arb_we;
      w_buf_waddr = w_arb_addr;
      w_buf_wdata = w_arb_data;
      if (r_state == ST_CLEAR) begin
         w_buf_we    = 1'b1;
         w_buf_waddr = r_clr_ptr;
         w_buf_wdata = FILL_CHAR;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_buf_we) begin
         r_buf[w_buf_waddr] <= w_buf_wdata;
      end
   end

   // ------------------------------------------------------- character tracking
   // o_character is the registered read port of the buffer; it only moves on a
   // drawing fall / ready rise, so it is stable while the driver is drawing.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_idx       <= '0;
         r_character <= FILL_CHAR;
      end else begin
         if (w_load) begin
            r_idx <= w_read_addr;
         end
         if (r_state == ST_CLEAR) begin
            r_character <= FILL_CHAR;
         end else if (w_load) begin
            // Write-through so a same-cycle write to the fetched slot is seen.
            r_character <= (w_arb_we && (w_arb_addr == w_read_addr)) ?
                           w_arb_data : r_buf[w_read_addr];
         end
      end
   end

   assign o_character = r_character;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lcd_frame_scheduler
// Directed self-checking bench for lcd_frame_scheduler: reset/clear timing,
// write arbitration, character feed, shift handshake, bypass and resync.
// -----------------------------------------------------------------------------
module tb_lcd_frame_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_a_valid, wr_b_valid;
   logic [4:0] wr_a_addr, wr_b_addr;
   logic [7:0] wr_a_data, wr_b_data;
   logic       wr_a_ready, wr_b_ready;
   logic       clr_req, shift_req, shift_dir;
   logic       busy;
   logic       drv_drawing, drv_ready;
   logic [7:0] character;
   logic [2:0] command_out;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_buf [32];

   always #5 clk = ~clk;

   lcd_frame_scheduler dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_wr_a_valid  (wr_a_valid),
      .i_wr_a_addr   (wr_a_addr),
      .i_wr_a_data   (wr_a_data),
      .o_wr_a_ready  (wr_a_ready),
      .i_wr_b_valid  (wr_b_valid),
      .i_wr_b_addr   (wr_b_addr),
      .i_wr_b_data   (wr_b_data),
      .o_wr_b_ready  (wr_b_ready),
      .i_clr_req     (clr_req),
      .i_shift_req   (shift_req),
      .i_shift_dir   (shift_dir),
      .o_busy        (busy),
      .i_drv_drawing (drv_drawing),
      .i_drv_ready   (drv_ready),
      .o_character   (character),
      .o_command_out (command_out)
   );

   // Driver model: resync via a ready rise, then 32 drawing pulses; the
   // character seen while drawing is high must match the expected buffer.
   task automatic scan_frame(input string tag);
      @(negedge clk) drv_ready = 1'b0;
      @(negedge clk) drv_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 32; k++) begin
         drv_drawing = 1'b1;
         @(negedge clk);
         checks++;
         if (character !== exp_buf[k]) begin
            failures++;
            $display("FAIL %s pulse %0d: character=%h expected=%h", tag, k, character, exp_buf[k]);
         end
         drv_drawing = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (character !== exp_buf[0]) begin
         failures++;
         $display("FAIL %s wrap: character=%h expected=%h", tag, character, exp_buf[0]);
      end
      $display("scan %s done", tag);
   endtask

   task automatic write_a(input logic [4:0] addr, input logic [7:0] data);
      @(negedge clk);
      wr_a_valid = 1'b1;
      wr_a_addr  = addr;
      wr_a_data  = data;
      #1;
      checks++;
      if (wr_a_ready !== 1'b1) begin
         failures++;
         $display("FAIL write_a ready addr %0d: ready=%b expected=1", addr, wr_a_ready);
      end
      @(negedge clk);
      wr_a_valid = 1'b0;
      $display("write A addr=%0d data=%h", addr, data);
   endtask

   // Counts busy-high cycles starting at the current negedge (bounded).
   task automatic count_busy(input string tag, input bit poke_clr);
      int cnt;
      bit cmd_seen;
      cnt      = 0;
      cmd_seen = 1'b0;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         if (command_out !== 3'b000) cmd_seen = 1'b1;
         clr_req = poke_clr && (cnt == 10);
         @(negedge clk);
      end
      clr_req = 1'b0;
      checks++;
      if (cnt != 32) begin
         failures++;
         $display("FAIL %s busy_cycles: got=%0d expected=32", tag, cnt);
      end
      checks++;
      if (cmd_seen) begin
         failures++;
         $display("FAIL %s command_during_clear: got=nonzero expected=000", tag);
      end
      $display("%s busy cycles=%0d", tag, cnt);
   endtask

   task automatic test_reset();
      bit ready_seen;
      int cnt;
      reset = 1'b1;
      wr_a_valid = 1'b1; wr_a_addr = 5'd0; wr_a_data = 8'h20;
      wr_b_valid = 1'b0; wr_b_addr = 5'd0; wr_b_data = 8'h00;
      clr_req = 1'b0; shift_req = 1'b0; shift_dir = 1'b0;
      drv_drawing = 1'b0; drv_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (character !== 8'h20) begin failures++; $display("FAIL reset character: got=%h expected=20", character); end
      checks++;
      if (command_out !== 3'b000) begin failures++; $display("FAIL reset command_out: got=%b expected=000", command_out); end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL reset busy: got=%b expected=1", busy); end
      ready_seen = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 100) begin
         cnt++;
         if (wr_a_ready !== 1'b0) ready_seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (cnt != 32) begin failures++; $display("FAIL reset busy_cycles: got=%0d expected=32", cnt); end
      checks++;
      if (ready_seen) begin failures++; $display("FAIL reset ready_while_busy: got=1 expected=0"); end
      checks++;
      if (wr_a_ready !== 1'b1) begin failures++; $display("FAIL reset ready_after_clear: got=%b expected=1", wr_a_ready); end
      wr_a_valid = 1'b0;
      $display("reset: busy cycles=%0d", cnt);
      for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
      scan_frame("reset_clear");
   endtask

   task automatic test_round_robin();
      logic exp_a [4];
      exp_a[0] = 1'b1; exp_a[1] = 1'b0; exp_a[2] = 1'b1; exp_a[3] = 1'b0;
      @(negedge clk);
      wr_a_valid = 1'b1; wr_a_addr = 5'd2; wr_a_data = 8'h41;
      wr_b_valid = 1'b1; wr_b_addr = 5'd3; wr_b_data = 8'h42;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (wr_a_ready !== exp_a[i] || wr_b_ready !== ~exp_a[i]) begin
            failures++;
            $display("FAIL rr cycle %0d: ready_a=%b ready_b=%b expected a=%b b=%b",
                     i, wr_a_ready, wr_b_ready, exp_a[i], ~exp_a[i]);
         end
         $display("rr cycle %0d grant a=%b b=%b", i, wr_a_ready, wr_b_ready);
         @(negedge clk);
      end
      wr_a_valid = 1'b0;
      wr_b_valid = 1'b0;
      exp_buf[2] = 8'h41;
      exp_buf[3] = 8'h42;
      scan_frame("round_robin");
   endtask

   task automatic test_write_a();
      write_a(5'd0, 8'h48);
      write_a(5'd17, 8'h69);
      exp_buf[0]  = 8'h48;
      exp_buf[17] = 8'h69;
      scan_frame("write_a");
   endtask

   task automatic test_shift();
      @(negedge clk);
      shift_req = 1'b1; shift_dir = 1'b1;
      @(negedge clk);
      shift_req = 1'b0;
      #1;
      checks++;
      if (command_out !== 3'b011) begin failures++; $display("FAIL shift issue: command_out=%b expected=011", command_out); end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL shift busy: got=%b expected=1", busy); end
      repeat (3) @(negedge clk);
      checks++;
      if (command_out !== 3'b011) begin failures++; $display("FAIL shift hold: command_out=%b expected=011", command_out); end
      drv_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (command_out !== 3'b000) begin failures++; $display("FAIL shift accepted: command_out=%b expected=000", command_out); end
      shift_req = 1'b1; shift_dir = 1'b0;
      @(negedge clk);
      shift_req = 1'b0;
      checks++;
      if (command_out !== 3'b000 || busy !== 1'b1) begin
         failures++;
         $display("FAIL shift wait: command_out=%b busy=%b expected 000/1", command_out, busy);
      end
      drv_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL shift done busy: got=%b expected=0", busy); end
      repeat (3) @(negedge clk);
      checks++;
      if (command_out !== 3'b000) begin failures++; $display("FAIL shift ignored second: command_out=%b expected=000", command_out); end
      $display("shift right: command/handshake sequence complete");
   endtask

   task automatic test_bypass();
      // Idx is 0 after the ready rise that ended the shift.
      @(negedge clk) drv_drawing = 1'b1;
      @(negedge clk);
      drv_drawing = 1'b0;
      wr_a_valid = 1'b1; wr_a_addr = 5'd1; wr_a_data = 8'h5A;
      #1;
      checks++;
      if (wr_a_ready !== 1'b1) begin failures++; $display("FAIL bypass ready: got=%b expected=1", wr_a_ready); end
      @(negedge clk);
      wr_a_valid = 1'b0;
      checks++;
      if (character !== 8'h5A) begin failures++; $display("FAIL bypass character: got=%h expected=5a", character); end
      exp_buf[1] = 8'h5A;
      // Ready rise coinciding with a drawing fall: resync to entry 0.
      drv_ready = 1'b0;
      @(negedge clk) drv_drawing = 1'b1;
      @(negedge clk);
      drv_drawing = 1'b0;
      drv_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (character !== 8'h48) begin failures++; $display("FAIL resync_wins character: got=%h expected=48", character); end
      drv_drawing = 1'b1;
      @(negedge clk) drv_drawing = 1'b0;
      @(negedge clk);
      checks++;
      if (character !== 8'h5A) begin failures++; $display("FAIL after_resync character: got=%h expected=5a", character); end
      $display("bypass/resync checks complete");
   endtask

   task automatic test_clear();
      write_a(5'd5, 8'h77);
      @(negedge clk);
      clr_req = 1'b1; shift_req = 1'b1; shift_dir = 1'b0;
      @(negedge clk);
      clr_req = 1'b0; shift_req = 1'b0;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL clear busy: got=%b expected=1", busy); end
      count_busy("clear", 1'b1);
      for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
      scan_frame("clear");
   endtask

   task automatic test_reset_mid_shift();
      @(negedge clk);
      shift_req = 1'b1; shift_dir = 1'b0;
      @(negedge clk);
      shift_req = 1'b0;
      checks++;
      if (command_out !== 3'b010) begin failures++; $display("FAIL mid_shift issue: command_out=%b expected=010", command_out); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (command_out !== 3'b000) begin failures++; $display("FAIL mid_shift reset command_out: got=%b expected=000", command_out); end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL mid_shift reset busy: got=%b expected=1", busy); end
      checks++;
      if (character !== 8'h20) begin failures++; $display("FAIL mid_shift reset character: got=%h expected=20", character); end
      count_busy("reset_mid_shift", 1'b0);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_write_a();
      test_shift();
      test_bypass();
      test_clear();
      test_reset_mid_shift();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
